// File: rtl/decode_stage_pipe.sv
// Decode stage with registered ID/EX output: field split, bypassed operand read,
// control/immediate generation, load-use bubble insertion and a saturating bubble counter.
module decode_stage_pipe #(
    parameter int ADDR_SIZE  = 32,
    parameter int INSTR_SIZE = 32,
    parameter int REG_SIZE   = 32,
    parameter int REG_ADDR   = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [ADDR_SIZE-1:0]  pc,
    input  logic [INSTR_SIZE-1:0] instruction,
    input  logic                  flush,
    input  logic                  hold,
    output logic [REG_ADDR-1:0]   src_reg1,
    output logic [REG_ADDR-1:0]   src_reg2,
    input  logic [REG_SIZE-1:0]   rin_reg1,
    input  logic [REG_SIZE-1:0]   rin_reg2,
    input  logic                  wb_we,
    input  logic [REG_ADDR-1:0]   wb_dst,
    input  logic [REG_SIZE-1:0]   wb_data,
    output logic                  stall,
    output logic                  out_valid,
    output logic [ADDR_SIZE-1:0]  out_pc,
    output logic [REG_SIZE-1:0]   rout_reg1,
    output logic [REG_SIZE-1:0]   rout_reg2,
    output logic [REG_ADDR-1:0]   dest_reg,
    output logic [ADDR_SIZE-1:0]  mimmediat,
    output logic                  regwrite,
    output logic                  memtoreg,
    output logic                  branch,
    output logic                  jump,
    output logic                  memwrite,
    output logic                  memread,
    output logic                  byteword,
    output logic                  alusrc,
    output logic [2:0]            aluop,
    output logic [CNT_W-1:0]      bubble_count
);

    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       branch;
        logic       jump;
        logic       memwrite;
        logic       memread;
        logic       byteword;
        logic       alusrc;
        logic [2:0] aluop;
    } ctrl_t;

    localparam logic [6:0] OP_ADD  = 7'h00;
    localparam logic [6:0] OP_SUB  = 7'h01;
    localparam logic [6:0] OP_MUL  = 7'h02;
    localparam logic [6:0] OP_LDB  = 7'h10;
    localparam logic [6:0] OP_LDW  = 7'h11;
    localparam logic [6:0] OP_STB  = 7'h12;
    localparam logic [6:0] OP_STW  = 7'h13;
    localparam logic [6:0] OP_MOV  = 7'h14;
    localparam logic [6:0] OP_BEQ  = 7'h30;
    localparam logic [6:0] OP_JUMP = 7'h31;

    logic [6:0]           opcode;
    logic [REG_ADDR-1:0]  dst_dec;
    logic [14:0]          imm_beq;
    logic [19:0]          imm_jmp;
    logic [14:0]          imm_def;
    logic [ADDR_SIZE-1:0] imm_dec;
    logic [REG_SIZE-1:0]  opnd1;
    logic [REG_SIZE-1:0]  opnd2;
    ctrl_t                ctrl_dec;
    ctrl_t                ctrl_q;
    logic                 loaduse;

    assign opcode   = instruction[31:25];
    assign src_reg1 = REG_ADDR'(instruction[19:15]);
    assign src_reg2 = REG_ADDR'(instruction[14:10]);
    assign dst_dec  = REG_ADDR'(instruction[24:20]);
    assign imm_beq  = {instruction[24:20], instruction[9:0]};
    assign imm_jmp  = {instruction[24:20], instruction[14:0]};
    assign imm_def  = instruction[14:0];

    always_comb begin
        ctrl_dec = '0;
        unique case (opcode)
            OP_ADD: begin ctrl_dec.regwrite = 1'b1; ctrl_dec.aluop = 3'd0; end
            OP_SUB: begin ctrl_dec.regwrite = 1'b1; ctrl_dec.aluop = 3'd1; end
            OP_MUL: begin ctrl_dec.regwrite = 1'b1; ctrl_dec.aluop = 3'd2; end
            OP_LDB, OP_LDW: begin
                ctrl_dec.regwrite = 1'b1;
                ctrl_dec.memtoreg = 1'b1;
                ctrl_dec.memread  = 1'b1;
                ctrl_dec.alusrc   = 1'b1;
                ctrl_dec.byteword = opcode[0];
            end
            OP_STB, OP_STW: begin
                ctrl_dec.memwrite = 1'b1;
                ctrl_dec.alusrc   = 1'b1;
                ctrl_dec.byteword = opcode[0];
            end
            OP_MOV: begin
                ctrl_dec.regwrite = 1'b1;
                ctrl_dec.alusrc   = 1'b1;
                ctrl_dec.aluop    = 3'd3;
            end
            OP_BEQ:  begin ctrl_dec.branch = 1'b1; ctrl_dec.aluop = 3'd1; end
            OP_JUMP: ctrl_dec.jump = 1'b1;
            default: ctrl_dec = '0;
        endcase
    end

    always_comb begin
        unique case (opcode)
            OP_BEQ:  imm_dec = {{(ADDR_SIZE-15){imm_beq[14]}}, imm_beq};
            OP_JUMP: imm_dec = {{(ADDR_SIZE-20){imm_jmp[19]}}, imm_jmp};
            default: imm_dec = {{(ADDR_SIZE-15){imm_def[14]}}, imm_def};
        endcase
    end

    // r0 is hardwired, so a matching writeback to r0 never needs a separate check
    always_comb begin
        opnd1 = rin_reg1;
        if (src_reg1 == '0)
            opnd1 = '0;
        else if (wb_we && wb_dst == src_reg1)
            opnd1 = wb_data;
        opnd2 = rin_reg2;
        if (src_reg2 == '0)
            opnd2 = '0;
        else if (wb_we && wb_dst == src_reg2)
            opnd2 = wb_data;
    end

    assign loaduse = in_valid & out_valid & ctrl_q.memread & (dest_reg != '0) &
                     ((dest_reg == src_reg1) | (dest_reg == src_reg2));
    assign stall   = ~flush & (hold | loaduse);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            rout_reg1    <= '0;
            rout_reg2    <= '0;
            dest_reg     <= '0;
            mimmediat    <= '0;
            ctrl_q       <= '0;
            bubble_count <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            ctrl_q    <= '0;
        end else if (!hold) begin
            if (loaduse) begin
                // bubble: data fields keep their last values
                out_valid <= 1'b0;
                ctrl_q    <= '0;
                if (bubble_count != '1)
                    bubble_count <= bubble_count + CNT_W'(1);
            end else begin
                out_valid <= in_valid;
                out_pc    <= pc;
                rout_reg1 <= opnd1;
                rout_reg2 <= opnd2;
                dest_reg  <= dst_dec;
                mimmediat <= imm_dec;
                ctrl_q    <= in_valid ? ctrl_dec : '0;
            end
        end
    end

    assign regwrite = ctrl_q.regwrite;
    assign memtoreg = ctrl_q.memtoreg;
    assign branch   = ctrl_q.branch;
    assign jump     = ctrl_q.jump;
    assign memwrite = ctrl_q.memwrite;
    assign memread  = ctrl_q.memread;
    assign byteword = ctrl_q.byteword;
    assign alusrc   = ctrl_q.alusrc;
    assign aluop    = ctrl_q.aluop;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: directed scenarios plus random traffic checked against
// a cycle model of the ID/EX register; a second instance with CNT_W=2 covers saturation.
module tb_decode_stage_pipe;

    logic        clk = 1'b0, reset = 1'b0, in_valid = 1'b0, flush = 1'b0, hold = 1'b0;
    logic        wb_we = 1'b0;
    logic [31:0] pc = '0, instruction = '0, rin_reg1 = '0, rin_reg2 = '0, wb_data = '0;
    logic [4:0]  wb_dst = '0;

    logic [4:0]  src_reg1, src_reg2, dest_reg;
    logic        stall, out_valid, regwrite, memtoreg, branch, jump, memwrite, memread, byteword, alusrc;
    logic [31:0] out_pc, rout_reg1, rout_reg2, mimmediat;
    logic [2:0]  aluop;
    logic [15:0] bubble_count;

    logic [4:0]  s_src_reg1, s_src_reg2, s_dest_reg;
    logic        s_stall, s_out_valid, s_regwrite, s_memtoreg, s_branch, s_jump, s_memwrite, s_memread;
    logic        s_byteword, s_alusrc;
    logic [31:0] s_out_pc, s_rout_reg1, s_rout_reg2, s_mimmediat;
    logic [2:0]  s_aluop;
    logic [1:0]  s_bubble_count;

    always #5 clk = ~clk;

    decode_stage_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .pc(pc), .instruction(instruction),
        .flush(flush), .hold(hold), .src_reg1(src_reg1), .src_reg2(src_reg2),
        .rin_reg1(rin_reg1), .rin_reg2(rin_reg2), .wb_we(wb_we), .wb_dst(wb_dst), .wb_data(wb_data),
        .stall(stall), .out_valid(out_valid), .out_pc(out_pc), .rout_reg1(rout_reg1),
        .rout_reg2(rout_reg2), .dest_reg(dest_reg), .mimmediat(mimmediat), .regwrite(regwrite),
        .memtoreg(memtoreg), .branch(branch), .jump(jump), .memwrite(memwrite), .memread(memread),
        .byteword(byteword), .alusrc(alusrc), .aluop(aluop), .bubble_count(bubble_count)
    );

    decode_stage_pipe #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .pc(pc), .instruction(instruction),
        .flush(flush), .hold(hold), .src_reg1(s_src_reg1), .src_reg2(s_src_reg2),
        .rin_reg1(rin_reg1), .rin_reg2(rin_reg2), .wb_we(wb_we), .wb_dst(wb_dst), .wb_data(wb_data),
        .stall(s_stall), .out_valid(s_out_valid), .out_pc(s_out_pc), .rout_reg1(s_rout_reg1),
        .rout_reg2(s_rout_reg2), .dest_reg(s_dest_reg), .mimmediat(s_mimmediat), .regwrite(s_regwrite),
        .memtoreg(s_memtoreg), .branch(s_branch), .jump(s_jump), .memwrite(s_memwrite),
        .memread(s_memread), .byteword(s_byteword), .alusrc(s_alusrc), .aluop(s_aluop),
        .bubble_count(s_bubble_count)
    );

    // ctl = {regwrite, memtoreg, branch, jump, memwrite, memread, byteword, alusrc, aluop[2:0]}
    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  dst;
        logic [31:0] imm;
        logic [10:0] ctl;
    } idex_t;

    idex_t obs, s_obs, m;
    int    m_bub = 0;
    int    total = 0, bad = 0;

    assign obs   = {out_valid, out_pc, rout_reg1, rout_reg2, dest_reg, mimmediat, regwrite, memtoreg,
                    branch, jump, memwrite, memread, byteword, alusrc, aluop};
    assign s_obs = {s_out_valid, s_out_pc, s_rout_reg1, s_rout_reg2, s_dest_reg, s_mimmediat,
                    s_regwrite, s_memtoreg, s_branch, s_jump, s_memwrite, s_memread, s_byteword,
                    s_alusrc, s_aluop};

    localparam logic [6:0] ADD = 7'h00, SUB = 7'h01, MUL = 7'h02, LDB = 7'h10, LDW = 7'h11;
    localparam logic [6:0] STB = 7'h12, STW = 7'h13, MOV = 7'h14, BEQ = 7'h30, JMP = 7'h31;

    function automatic logic [10:0] ctl_of(logic [6:0] op);
        case (op)
            ADD: return 11'b1_0_0_0_0_0_0_0_000;
            SUB: return 11'b1_0_0_0_0_0_0_0_001;
            MUL: return 11'b1_0_0_0_0_0_0_0_010;
            LDB: return 11'b1_1_0_0_0_1_0_1_000;
            LDW: return 11'b1_1_0_0_0_1_1_1_000;
            STB: return 11'b0_0_0_0_1_0_0_1_000;
            STW: return 11'b0_0_0_0_1_0_1_1_000;
            MOV: return 11'b1_0_0_0_0_0_0_1_011;
            BEQ: return 11'b0_0_1_0_0_0_0_0_001;
            JMP: return 11'b0_0_0_1_0_0_0_0_000;
            default: return 11'b0;
        endcase
    endfunction

    // immediate as a signed integer of the given field width
    function automatic logic [31:0] imm_of(logic [31:0] ins);
        int raw, w;
        if (ins[31:25] == BEQ) begin
            raw = int'(ins[24:20]) * 1024 + int'(ins[9:0]); w = 15;
        end else if (ins[31:25] == JMP) begin
            raw = int'(ins[24:20]) * 32768 + int'(ins[14:0]); w = 20;
        end else begin
            raw = int'(ins[14:0]); w = 15;
        end
        if (raw >= (1 << (w - 1))) raw = raw - (1 << w);
        return 32'(raw);
    endfunction

    function automatic logic [31:0] operand(logic [4:0] src, logic [31:0] rin);
        if (src == 0) return 32'd0;
        if (wb_we && wb_dst == src) return wb_data;
        return rin;
    endfunction

    function automatic logic model_lu();
        return in_valid && m.v && m.ctl[5] && m.dst != 0 &&
               (m.dst == instruction[19:15] || m.dst == instruction[14:10]);
    endfunction

    function automatic logic model_stall();
        return !flush && (hold || model_lu());
    endfunction

    function automatic logic [31:0] mk(logic [6:0] op, logic [4:0] d, logic [4:0] s1, logic [4:0] s2,
                                       logic [9:0] lo);
        return {op, d, s1, s2, lo};
    endfunction

    // advance model and clock; called at posedge+1, returns at next posedge+1
    task automatic tick();
        idex_t n = m;
        int    nb = m_bub;
        logic  lu = model_lu();
        if (flush) begin
            n.v = 1'b0; n.ctl = '0;
        end else if (!hold) begin
            if (lu) begin
                n.v = 1'b0; n.ctl = '0; nb++;
            end else begin
                n.v   = in_valid;
                n.pc  = pc;
                n.r1  = operand(instruction[19:15], rin_reg1);
                n.r2  = operand(instruction[14:10], rin_reg2);
                n.dst = instruction[24:20];
                n.imm = imm_of(instruction);
                n.ctl = in_valid ? ctl_of(instruction[31:25]) : 11'b0;
            end
        end
        @(posedge clk); #1;
        m = n; m_bub = nb;
    endtask

    task automatic drive(logic [31:0] ins, logic v);
        instruction = ins; in_valid = v;
        pc = $urandom; rin_reg1 = $urandom; rin_reg2 = $urandom;
    endtask

    task automatic test_reset();
        drive(mk(ADD, 9, 1, 2, 10'h155), 1'b1); tick();
        drive(mk(LDW, 5, 1, 2, 0), 1'b1); tick();
        drive(mk(ADD, 6, 5, 1, 0), 1'b1);
        #1;
        total++;
        if (stall !== 1'b1) begin bad++; $display("FAIL reset_prestall: stall=%b want 1", stall); end
        #2 reset = 1'b0;
        #1;
        total++;
        if (obs !== '0 || s_obs !== '0 || bubble_count !== 16'd0 || s_bubble_count !== 2'd0) begin
            bad++; $display("FAIL reset_async: obs=%h bub=%0d want 0", obs, bubble_count);
        end
        m = '0; m_bub = 0;
        #2 reset = 1'b1;
        drive(mk(LDW, 3, 1, 2, 10'h0F0), 1'b1); tick();
        total++;
        if ({out_valid, memread, byteword, alusrc, dest_reg} !== {4'b1111, 5'd3}) begin
            bad++; $display("FAIL reset_first_ldw: v/mr/bw/as/dst=%b want 1111_00011",
                            {out_valid, memread, byteword, alusrc, dest_reg});
        end
        total++;
        if (obs !== m) begin bad++; $display("FAIL reset_first_model: got %h want %h", obs, m); end
    endtask

    task automatic test_immediates();
        drive(mk(BEQ, 5'b10000, 1, 2, 10'h000), 1'b1); tick();
        total++;
        if (mimmediat !== 32'hFFFFC000) begin bad++; $display("FAIL imm_beq: got %h want FFFFC000", mimmediat); end
        drive(mk(JMP, 5'd0, 1, 5'b11111, 10'h3FF), 1'b1); tick();
        total++;
        if (mimmediat !== 32'h00007FFF) begin bad++; $display("FAIL imm_jump: got %h want 00007FFF", mimmediat); end
        drive(mk(ADD, 5'd4, 1, 5'b10000, 10'h000), 1'b1); tick();
        total++;
        if (mimmediat !== 32'hFFFFC000) begin bad++; $display("FAIL imm_add: got %h want FFFFC000", mimmediat); end
        total++;
        if (obs !== m) begin bad++; $display("FAIL imm_model: got %h want %h", obs, m); end
    endtask

    task automatic test_loaduse();
        drive(mk(LDW, 5, 1, 2, 0), 1'b1); tick();
        drive(mk(ADD, 6, 5, 1, 0), 1'b1);
        #1;
        total++;
        if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall: got %b want 1", stall); end
        tick();
        total++;
        if (out_valid !== 1'b0 || obs !== m) begin bad++; $display("FAIL lu_bubble: got %h want %h", obs, m); end
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL lu_stall_once: got %b want 0", stall); end
        tick();
        total++;
        if (out_valid !== 1'b1 || dest_reg !== 5'd6 || regwrite !== 1'b1 || bubble_count !== 16'd1) begin
            bad++; $display("FAIL lu_issue: v=%b dst=%0d bub=%0d want 1 6 1", out_valid, dest_reg, bubble_count);
        end
        drive(mk(LDW, 0, 1, 2, 0), 1'b1); tick();
        drive(mk(ADD, 6, 0, 1, 0), 1'b1);
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL lu_r0_stall: got %b want 0", stall); end
        tick();
        total++;
        if (out_valid !== 1'b1 || bubble_count !== 16'd1) begin
            bad++; $display("FAIL lu_r0_issue: v=%b bub=%0d want 1 1", out_valid, bubble_count);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            drive(mk(LDB, 5'd9, 1, 2, 0), 1'b1); tick();
            drive(mk(SUB, 5'd2, 1, 5'd9, 0), 1'b1); tick(); tick();
        end
        total++;
        if (s_bubble_count !== 2'd3 || bubble_count !== 16'd6) begin
            bad++; $display("FAIL saturation: sat=%0d full=%0d want 3 6", s_bubble_count, bubble_count);
        end
    endtask

    task automatic test_bypass();
        drive(mk(ADD, 4, 7, 2, 0), 1'b1);
        rin_reg1 = 32'h11; wb_we = 1'b1; wb_dst = 5'd7; wb_data = 32'hABCD;
        tick();
        total++;
        if (rout_reg1 !== 32'hABCD) begin bad++; $display("FAIL bypass_hit: got %h want ABCD", rout_reg1); end
        drive(mk(ADD, 4, 0, 2, 0), 1'b1);
        rin_reg1 = 32'h11; wb_dst = 5'd0;
        tick();
        total++;
        if (rout_reg1 !== 32'h0) begin bad++; $display("FAIL bypass_r0: got %h want 0", rout_reg1); end
        drive(mk(ADD, 4, 7, 2, 0), 1'b1);
        rin_reg1 = 32'h11; wb_we = 1'b0; wb_dst = 5'd7;
        tick();
        total++;
        if (rout_reg1 !== 32'h11) begin bad++; $display("FAIL bypass_off: got %h want 11", rout_reg1); end
    endtask

    task automatic test_hold_flush();
        idex_t snap;
        drive(mk(SUB, 8, 1, 2, 10'h2A5), 1'b1); tick();
        snap = m;
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(mk(MOV, 5'(i + 10), 3, 4, 10'(i)), 1'b1);
            #1;
            total++;
            if (stall !== 1'b1) begin bad++; $display("FAIL hold_stall: got %b want 1", stall); end
            tick();
            total++;
            if (obs !== snap) begin bad++; $display("FAIL hold_frozen: got %h want %h", obs, snap); end
        end
        flush = 1'b1;
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall: got %b want 0", stall); end
        tick();
        total++;
        if (out_valid !== 1'b0 || obs !== m) begin bad++; $display("FAIL flush_kill: got %h want %h", obs, m); end
        hold = 1'b0; flush = 1'b0;
    endtask

    task automatic test_random();
        logic [6:0] ops [11];
        logic [6:0] op;
        int         sat;
        ops = '{ADD, SUB, MUL, LDB, LDW, STB, STW, MOV, BEQ, JMP, 7'h55};
        for (int c = 0; c < 300; c++) begin
            if (!model_stall()) begin
                op = ops[$urandom_range(0, 10)];
                drive(mk(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                         5'($urandom_range(0, 3)), 10'($urandom)), $urandom_range(0, 3) != 0);
            end
            hold   = $urandom_range(0, 7) == 0;
            flush  = $urandom_range(0, 9) == 0;
            wb_we  = $urandom_range(0, 1) == 1;
            wb_dst = 5'($urandom_range(0, 3));
            wb_data = $urandom;
            #1;
            total++;
            if (stall !== model_stall() || src_reg1 !== instruction[19:15] || src_reg2 !== instruction[14:10]) begin
                bad++; $display("FAIL rand_comb[%0d]: stall=%b want %b", c, stall, model_stall());
            end
            tick();
            total++;
            if (obs !== m || s_obs !== m) begin
                bad++; $display("FAIL rand_idex[%0d]: got %h want %h", c, obs, m);
            end
            sat = (m_bub > 3) ? 3 : m_bub;
            total++;
            if (bubble_count !== 16'(m_bub) || s_bubble_count !== 2'(sat)) begin
                bad++; $display("FAIL rand_bub[%0d]: got %0d/%0d want %0d/%0d", c, bubble_count,
                                s_bubble_count, m_bub, sat);
            end
        end
        hold = 1'b0; flush = 1'b0; wb_we = 1'b0;
    endtask

    initial begin
        m = '0;
        #12 reset = 1'b1;
        test_reset();
        test_immediates();
        test_loaduse();
        test_saturation();
        test_bypass();
        test_hold_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
